// File: rtl/morse_symbol_shifter_if.sv
// Symbol-in / letter-out signal bundle for morse_symbol_shifter.
// The slave modport is the shifter's view; the master modport is the surrounding logic's view.
interface morse_symbol_shifter_if #(
  parameter int MAX_LEN = 5,
  parameter int LEN_W   = 3
);
  logic               sym_valid;
  logic               sym_bit;
  logic               commit;
  logic               clear;
  logic               out_ready;
  logic               out_valid;
  logic [MAX_LEN-1:0] out_code;
  logic [LEN_W-1:0]   out_len;
  logic               out_ovf;
  logic [LEN_W-1:0]   acc_len;
  logic               sym_lost;

  modport slave (
    input  sym_valid, sym_bit, commit, clear, out_ready,
    output out_valid, out_code, out_len, out_ovf, acc_len, sym_lost
  );

  modport master (
    output sym_valid, sym_bit, commit, clear, out_ready,
    input  out_valid, out_code, out_len, out_ovf, acc_len, sym_lost
  );
endinterface

// File: rtl/morse_symbol_shifter.sv
// Accumulates the dot/dash symbols of one Morse letter into a code word and length.
// On commit, the letter moves to a registered valid/ready output stage.
module morse_symbol_shifter #(
  parameter int MAX_LEN   = 5,
  parameter int LEN_W     = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  morse_symbol_shifter_if.slave       bus
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    ACCUM   = 2'd1,
    PENDING = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] MaxLenL = LEN_W'(MAX_LEN);

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] acc_code_q, acc_code_d;
  logic [LEN_W-1:0]   acc_len_q, acc_len_d;
  logic               acc_ovf_q, acc_ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [MAX_LEN-1:0] out_code_q, out_code_d;
  logic [LEN_W-1:0]   out_len_q, out_len_d;
  logic               out_ovf_q, out_ovf_d;
  logic               sym_lost_q, sym_lost_d;

  logic [MAX_LEN-1:0] app_code;
  logic [LEN_W-1:0]   app_len;
  logic               app_ovf;
  logic               slot_free;
  logic               xfer;
  logic [MAX_LEN-1:0] xfer_code;
  logic [LEN_W-1:0]   xfer_len;
  logic               xfer_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      acc_code_q  <= '0;
      acc_len_q   <= '0;
      acc_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_len_q   <= '0;
      out_ovf_q   <= 1'b0;
      sym_lost_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_code_q  <= acc_code_d;
      acc_len_q   <= acc_len_d;
      acc_ovf_q   <= acc_ovf_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_len_q   <= out_len_d;
      out_ovf_q   <= out_ovf_d;
      sym_lost_q  <= sym_lost_d;
    end
  end

  // app_* is the accumulator as it would look with this cycle's symbol appended,
  // so a symbol arriving together with commit lands in the committed letter.
  always_comb begin
    app_code = acc_code_q;
    app_len  = acc_len_q;
    app_ovf  = acc_ovf_q;
    if (bus.sym_valid) begin
      if (acc_len_q < MaxLenL) begin
        if (MSB_FIRST) begin
          app_code = {acc_code_q[MAX_LEN-2:0], bus.sym_bit};
        end else begin
          app_code = acc_code_q | (MAX_LEN'(bus.sym_bit) << acc_len_q);
        end
        app_len = acc_len_q + LEN_W'(1);
      end else begin
        app_ovf = 1'b1;
      end
    end
  end

  assign slot_free = !out_valid_q || bus.out_ready;

  always_comb begin
    state_d     = state_q;
    acc_code_d  = acc_code_q;
    acc_len_d   = acc_len_q;
    acc_ovf_d   = acc_ovf_q;
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    out_len_d   = out_len_q;
    out_ovf_d   = out_ovf_q;
    sym_lost_d  = sym_lost_q;
    xfer        = 1'b0;
    xfer_code   = app_code;
    xfer_len    = app_len;
    xfer_ovf    = app_ovf;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (bus.clear) begin
      acc_code_d = '0;
      acc_len_d  = '0;
      acc_ovf_d  = 1'b0;
      state_d    = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY, ACCUM: begin
          acc_code_d = app_code;
          acc_len_d  = app_len;
          acc_ovf_d  = app_ovf;
          if (bus.sym_valid) begin
            state_d = ACCUM;
          end
          if (bus.commit && (state_q == ACCUM || bus.sym_valid)) begin
            if (slot_free) begin
              xfer = 1'b1;
            end else begin
              state_d = PENDING;
            end
          end
        end
        PENDING: begin
          if (bus.sym_valid) begin
            sym_lost_d = 1'b1;
          end
          xfer_code = acc_code_q;
          xfer_len  = acc_len_q;
          xfer_ovf  = acc_ovf_q;
          if (slot_free) begin
            xfer = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    // A transfer empties the accumulator and overrides any handshake-driven drop of out_valid.
    if (xfer) begin
      out_valid_d = 1'b1;
      out_code_d  = xfer_code;
      out_len_d   = xfer_len;
      out_ovf_d   = xfer_ovf;
      acc_code_d  = '0;
      acc_len_d   = '0;
      acc_ovf_d   = 1'b0;
      state_d     = EMPTY;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_code  = out_code_q;
  assign bus.out_len   = out_len_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.acc_len   = acc_len_q;
  assign bus.sym_lost  = sym_lost_q;

endmodule

// File: doc/morse_symbol_shifter.md
Name: morse_symbol_shifter

Overview:
- Parametrised successor to the team's fixed 5-bit serial-in shift register.
- Accumulates dot/dash symbols of one Morse letter into a code word with a length count and a per-letter overflow flag.
- On commit, hands the letter to a registered valid/ready output stage for the downstream lookup table.
- Sits between the dot/dash timing classifier and the character decoder.

Parameters:
- MAX_LEN, 5: maximum symbols per letter; width of the code word.
- LEN_W, 3: width of the length fields; must satisfy 2^LEN_W > MAX_LEN.
- MSB_FIRST, 1: symbol ordering.
  - 1: shift left; the newest symbol enters bit 0, so the first symbol ends at bit len-1.
  - 0: the first symbol is written to bit 0 and the k-th symbol to bit k-1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- sym_valid  in  1  one symbol presented this cycle.
- sym_bit  in  1  0 = dot, 1 = dash.
- commit  in  1  end-of-letter strobe.
- clear  in  1  synchronous discard of the letter being accumulated.
- out_ready  in  1  downstream accepts the output.
- out_valid  out  1  output letter held.
- out_code  out  MAX_LEN  letter code; bits at and above out_len are 0.
- out_len  out  LEN_W  symbol count, 1..MAX_LEN.
- out_ovf  out  1  letter had more than MAX_LEN symbols.
- acc_len  out  LEN_W  symbols currently accumulated.
- sym_lost  out  1  sticky: a symbol arrived while PENDING.

Behaviour:
- Reset (async): all registers and outputs go to 0, state EMPTY. This applies mid-operation, including in PENDING or with out_valid=1.
- Priority each cycle: reset > clear > commit/sym_valid. clear zeroes the accumulator, acc_len, the overflow flag and any pending commit, and returns to EMPTY. It does not touch the output stage or sym_lost.
- Append: when sym_valid=1 and acc_len<MAX_LEN, the symbol is shifted/written per MSB_FIRST and acc_len increments.
  - When acc_len==MAX_LEN, the symbol is dropped and the internal ovf flag sets (held until the letter is transferred or cleared).
- Simultaneous sym_valid and commit: the symbol belongs to the committed letter; append happens first, then commit.
- Output slot free means out_valid==0, or out_valid&&out_ready in this same cycle.
- States:
  - EMPTY (acc_len==0):
    - sym_valid → ACCUM.
    - commit with no symbol is ignored and produces no output.
  - ACCUM:
    - commit with slot free: next edge loads out_code/out_len/out_ovf, sets out_valid=1, clears the accumulator → EMPTY.
    - commit with slot busy → PENDING; the accumulator is frozen.
  - PENDING:
    - Waits for a free slot, then transfers exactly as in ACCUM → EMPTY.
    - sym_valid here is dropped and sets sym_lost; the sym_lost flag clears only on reset.
    - Further commits are ignored.
- Latency: commit at edge N gives out_valid=1 after edge N+1 (one register stage); there is no combinational path from inputs to outputs.
- Output stage:
  - Holds out_code/out_len/out_ovf stable while out_valid&&!out_ready.
  - The handshake completes on an edge with out_valid&&out_ready; out_valid drops unless a transfer lands on the same edge (back-to-back letters allowed).
- acc_len reflects the registered count; it never exceeds MAX_LEN and never wraps.

Test Plan (MAX_LEN=5, LEN_W=3):
1. MSB_FIRST=1, out_ready=1; symbols dash, dot, dot, then commit → one cycle later out_valid=1, out_code=5'b00100, out_len=3, out_ovf=0; out_valid=0 the following cycle. Repeat with MSB_FIRST=0 → out_code=5'b00001.
2. Six dash symbols, then commit → out_code=5'b11111, out_len=5, out_ovf=1; acc_len stays at 5 on the sixth symbol.
3. out_ready=0; letter dot,dash committed (out_code=5'b00001, len 2); then dot + commit → PENDING, acc_len=1. Send a dash during PENDING → sym_lost=1. Raise out_ready for 1 cycle → next output is out_code=5'b00000, len 1, out_valid continuously 1, and the dash is absent.
4. commit with acc_len=0, and clear after 3 symbols followed by commit → out_valid never rises; acc_len=0 after the clear.
5. sym_valid=1 (dash) and commit=1 in the same cycle after one dot, MSB_FIRST=1 → out_code=5'b00001, out_len=2.
6. Assert reset asynchronously between edges while in PENDING with out_valid=1 → out_valid, out_code, out_len, out_ovf, acc_len and sym_lost go to 0 immediately. The first letter after deassert behaves as in scenario 1.
